// File: rtl/mmio_master_if.sv
// ---------------------------------------------------------------------------
// mmio_master_if : MMIO device bus between the initiator and its responders.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mmio_master_if #(
  parameter int NDEV = 4
);
  logic                 mmio_read;
  logic                 mmio_write;
  logic [31:0]          mmio_addr;
  logic [31:0]          mmio_write_data;
  logic [NDEV-1:0]      mmio_work;
  logic [NDEV-1:0]      mmio_done;
  logic [NDEV*32-1:0]   mmio_read_data;

  modport master (
    output mmio_read, mmio_write, mmio_addr, mmio_write_data,
    input  mmio_work, mmio_done, mmio_read_data
  );

  modport slave (
    input  mmio_read, mmio_write, mmio_addr, mmio_write_data,
    output mmio_work, mmio_done, mmio_read_data
  );
endinterface

`default_nettype wire

// File: rtl/mmio_master.sv
// ---------------------------------------------------------------------------
// mmio_master : CPU-side MMIO bus initiator with decode check and timeout.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mmio_master #(
  parameter int NDEV    = 4,
  parameter int TIMEOUT = 255
) (
  input  wire logic        sys_clk,
  input  wire logic        rst_n,
  input  wire logic        cpu_req_read,
  input  wire logic        cpu_req_write,
  input  wire logic [31:0] cpu_addr,
  input  wire logic [31:0] cpu_wdata,
  output logic             cpu_stall,
  output logic             cpu_ack,
  output logic             cpu_fault,
  output logic [31:0]      cpu_rdata,
  output logic [31:0]      fault_addr,
  mmio_master_if.master    bus
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rd_nxt, wr_nxt, ack_nxt, fault_nxt;
  logic [31:0]   addr_nxt, wdata_nxt, rdata_nxt, faddr_nxt;
  logic          work_onehot, sel_done;
  logic [31:0]   sel_data;

  assign cpu_stall = (cpu_req_read | cpu_req_write) & ~cpu_ack;

  // Only the claiming device's done/data are seen; a multi-hot claim faults anyway.
  always_comb begin
    sel_done    = 1'b0;
    sel_data    = '0;
    work_onehot = (|bus.mmio_work) &&
                  !(|(bus.mmio_work & (bus.mmio_work - NDEV'(1))));
    for (int i = 0; i < NDEV; i++) begin
      if (bus.mmio_work[i]) begin
        sel_done = sel_done | bus.mmio_done[i];
        sel_data = sel_data | bus.mmio_read_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      cpu_ack             <= 1'b0;
      cpu_fault           <= 1'b0;
      cpu_rdata           <= '0;
      fault_addr          <= '0;
      bus.mmio_read       <= 1'b0;
      bus.mmio_write      <= 1'b0;
      bus.mmio_addr       <= '0;
      bus.mmio_write_data <= '0;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      cpu_ack             <= ack_nxt;
      cpu_fault           <= fault_nxt;
      cpu_rdata           <= rdata_nxt;
      fault_addr          <= faddr_nxt;
      bus.mmio_read       <= rd_nxt;
      bus.mmio_write      <= wr_nxt;
      bus.mmio_addr       <= addr_nxt;
      bus.mmio_write_data <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    fault_nxt = 1'b0;
    rdata_nxt = cpu_rdata;
    faddr_nxt = fault_addr;
    rd_nxt    = bus.mmio_read;
    wr_nxt    = bus.mmio_write;
    addr_nxt  = bus.mmio_addr;
    wdata_nxt = bus.mmio_write_data;

    case (state)
      IDLE: begin
        if (cpu_req_read && cpu_req_write) begin
          faddr_nxt = cpu_addr;
          rdata_nxt = '0;
          ack_nxt   = 1'b1;
          fault_nxt = 1'b1;
          state_nxt = ERR;
        end else if (cpu_req_read || cpu_req_write) begin
          rd_nxt    = cpu_req_read;
          wr_nxt    = cpu_req_write;
          addr_nxt  = cpu_addr;
          wdata_nxt = cpu_wdata;
          cnt_nxt   = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (!work_onehot || (!sel_done && cnt == CNT_LAST)) begin
          faddr_nxt = bus.mmio_addr;
          rdata_nxt = '0;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          ack_nxt   = 1'b1;
          fault_nxt = 1'b1;
          state_nxt = ERR;
        end else if (sel_done) begin
          rdata_nxt = bus.mmio_read ? sel_data : 32'h0;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          ack_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_master.sv
// ---------------------------------------------------------------------------
// tb_mmio_master : directed self-checking bench for mmio_master (TIMEOUT=8).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mmio_master;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_read, cpu_req_write;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_ack, cpu_fault;
  logic [31:0] cpu_rdata, fault_addr;

  mmio_master_if #(.NDEV(4)) bus ();

  mmio_master #(.NDEV(4), .TIMEOUT(8)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .cpu_req_read (cpu_req_read),
    .cpu_req_write(cpu_req_write),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .cpu_ack      (cpu_ack),
    .cpu_fault    (cpu_fault),
    .cpu_rdata    (cpu_rdata),
    .fault_addr   (fault_addr),
    .bus          (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Responders: dev0 ROM (single-cycle), dev1 never done, dev3 stray done.
  logic        done0 = 1'b0;
  logic        stray_done;
  logic [31:0] dev_wdata = '0;
  int          cyc = 0;

  always_comb begin
    case (bus.mmio_addr[31:12])
      20'hFFFFE: bus.mmio_work = 4'b0001;
      20'hFFFFF: bus.mmio_work = 4'b0010;
      20'hFFFFD: bus.mmio_work = 4'b0101;
      default:   bus.mmio_work = 4'b0000;
    endcase
  end
  assign bus.mmio_done      = {stray_done, 1'b0, 1'b0, done0};
  assign bus.mmio_read_data = {32'hBAD0BAD0, 32'h0, 32'h11111111,
                               done0 ? 32'hDEADBEEF : 32'h0};

  always @(posedge sys_clk) begin
    cyc   <= cyc + 1;
    done0 <= (bus.mmio_read | bus.mmio_write) & bus.mmio_work[0] & ~done0;
    if (done0 && bus.mmio_write) dev_wdata <= bus.mmio_write_data;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  int          ack_cyc, start_cyc;
  logic        ack_fault, ack_stall, stall0;
  logic [31:0] ack_rdata;
  logic [15:0] rmask, wmask;

  // Starts just after a rising edge (cycle 0); returns just after the edge ending the ack cycle.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    cpu_req_read  = rd;
    cpu_req_write = wr;
    cpu_addr      = a;
    cpu_wdata     = wd;
    ack_cyc   = -1;
    ack_fault = 1'b0;
    ack_stall = 1'b1;
    ack_rdata = 32'hxxxxxxxx;
    rmask     = '0;
    wmask     = '0;
    stall0    = 1'b0;
    start_cyc = cyc;
    for (int c = 0; c < 16; c++) begin
      @(negedge sys_clk);
      rmask[c] = bus.mmio_read;
      wmask[c] = bus.mmio_write;
      if (c == 0) stall0 = cpu_stall;
      if (cpu_ack) begin
        ack_cyc   = c;
        ack_fault = cpu_fault;
        ack_rdata = cpu_rdata;
        ack_stall = cpu_stall;
        break;
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drop_req(input string tag);
    cpu_req_read  = 1'b0;
    cpu_req_write = 1'b0;
    @(negedge sys_clk);
    check_val({tag, "_ack_pulse"}, {31'h0, cpu_ack}, 32'h0);
    @(posedge sys_clk);
    #1;
  endtask

  int s1, a1;

  initial begin
    rst_n = 1'b0;
    cpu_req_read = 1'b0;
    cpu_req_write = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    stray_done = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    @(negedge sys_clk);
    check_val("rst_ack",   {31'h0, cpu_ack},        32'h0);
    check_val("rst_fault", {31'h0, cpu_fault},      32'h0);
    check_val("rst_rw",    {30'h0, bus.mmio_read, bus.mmio_write}, 32'h0);
    check_val("rst_rdata", cpu_rdata,               32'h0);
    check_val("rst_addr",  bus.mmio_addr,           32'h0);
    check_val("rst_wdata", bus.mmio_write_data,     32'h0);
    check_val("rst_faddr", fault_addr,              32'h0);
    @(posedge sys_clk);
    #1;

    // ROM read
    txn(1'b1, 1'b0, 32'hFFFFE004, 32'h0);
    check_val("rd_ack_cyc", ack_cyc,           32'd3);
    check_val("rd_rmask",   {16'h0, rmask},    32'h0006);
    check_val("rd_wmask",   {16'h0, wmask},    32'h0000);
    check_val("rd_rdata",   ack_rdata,         32'hDEADBEEF);
    check_val("rd_fault",   {31'h0, ack_fault}, 32'h0);
    check_val("rd_stall0",  {31'h0, stall0},   32'h1);
    check_val("rd_stall_ack", {31'h0, ack_stall}, 32'h0);
    drop_req("rd");

    // Write to read-only ROM completes normally
    txn(1'b0, 1'b1, 32'hFFFFE000, 32'h12345678);
    check_val("wr_ack_cyc", ack_cyc,           32'd3);
    check_val("wr_wmask",   {16'h0, wmask},    32'h0006);
    check_val("wr_rmask",   {16'h0, rmask},    32'h0000);
    check_val("wr_rdata",   ack_rdata,         32'h0);
    check_val("wr_fault",   {31'h0, ack_fault}, 32'h0);
    check_val("wr_dev_data", dev_wdata,        32'h12345678);
    check_val("wr_addr",    bus.mmio_addr,     32'hFFFFE000);
    drop_req("wr");

    // Unmapped address
    txn(1'b1, 1'b0, 32'h00001000, 32'h0);
    check_val("dec_ack_cyc", ack_cyc,           32'd2);
    check_val("dec_fault",   {31'h0, ack_fault}, 32'h1);
    check_val("dec_rdata",   ack_rdata,         32'h0);
    check_val("dec_rmask",   {16'h0, rmask},    32'h0002);
    check_val("dec_faddr",   fault_addr,        32'h00001000);
    drop_req("dec");

    // Two devices claim the same address
    txn(1'b1, 1'b0, 32'hFFFFD010, 32'h0);
    check_val("multi_ack_cyc", ack_cyc,           32'd2);
    check_val("multi_fault",   {31'h0, ack_fault}, 32'h1);
    check_val("multi_faddr",   fault_addr,        32'hFFFFD010);
    drop_req("multi");

    // Timeout, with an unselected device pulsing done throughout
    stray_done = 1'b1;
    txn(1'b1, 1'b0, 32'hFFFFF000, 32'h0);
    check_val("to_ack_cyc", ack_cyc,           32'd9);
    check_val("to_rmask",   {16'h0, rmask},    32'h01FE);
    check_val("to_fault",   {31'h0, ack_fault}, 32'h1);
    check_val("to_rdata",   ack_rdata,         32'h0);
    check_val("to_faddr",   fault_addr,        32'hFFFFF000);
    stray_done = 1'b0;
    drop_req("to");

    // Illegal read+write
    txn(1'b1, 1'b1, 32'hFFFFE000, 32'hCAFEF00D);
    check_val("ill_ack_cyc", ack_cyc,           32'd1);
    check_val("ill_fault",   {31'h0, ack_fault}, 32'h1);
    check_val("ill_rwmask",  {rmask, wmask},    32'h0);
    check_val("ill_faddr",   fault_addr,        32'hFFFFE000);
    drop_req("ill");

    // Reset during REQ cycle 1
    cpu_req_read = 1'b1;
    cpu_addr     = 32'hFFFFE004;
    @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    cpu_req_read = 1'b0;
    @(negedge sys_clk);
    check_val("rst_mid_req_c1", {31'h0, bus.mmio_read}, 32'h1);
    @(posedge sys_clk);
    #1 rst_n = 1'b1;
    @(negedge sys_clk);
    check_val("rst_mid_req_c2", {31'h0, bus.mmio_read}, 32'h0);
    check_val("rst_mid_ack_c2", {31'h0, cpu_ack},       32'h0);
    @(negedge sys_clk);
    check_val("rst_mid_ack_c3", {31'h0, cpu_ack},       32'h0);
    @(posedge sys_clk);
    #1;

    // Back-to-back reads after reset
    txn(1'b1, 1'b0, 32'hFFFFE004, 32'h0);
    s1 = start_cyc;
    a1 = ack_cyc;
    check_val("b2b1_ack_cyc", a1,        32'd3);
    check_val("b2b1_rdata",   ack_rdata, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 32'hFFFFE008, 32'h0);
    check_val("b2b2_ack_abs", start_cyc - s1 + ack_cyc, 32'd7);
    check_val("b2b2_rdata",   ack_rdata,                32'hDEADBEEF);
    check_val("b2b2_fault",   {31'h0, ack_fault},       32'h0);
    drop_req("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_master.md
# mmio_master

Bus initiator for the MMIO device bus. It sits between the CPU load/store stage and all MMIO responders (ROM, peripherals). It drives the request/address/data lines and selects the responding device from its `mmio_work` claim. It waits for that device's `mmio_done`, returns read data or a fault to the CPU, and bounds every transaction with a timeout.

## Interface
- `NDEV`, 4: number of attached responders.
- `TIMEOUT`, 255: maximum REQ cycles before a transaction faults; range 2..65535.
- `sys_clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cpu_req_read`  in  1  CPU load request; held stable until `cpu_ack`.
- `cpu_req_write`  in  1  CPU store request; held stable until `cpu_ack`.
- `cpu_addr`  in  32  request byte address.
- `cpu_wdata`  in  32  store data.
- `cpu_stall`  out  1  combinational: (`cpu_req_read` | `cpu_req_write`) & !`cpu_ack`.
- `cpu_ack`  out  1  registered; one-cycle pulse that completes the transaction.
- `cpu_fault`  out  1  valid with `cpu_ack`: 1 = decode error, timeout, or illegal request.
- `cpu_rdata`  out  32  valid with `cpu_ack`; 0 on writes and faults.
- `fault_addr`  out  32  address of the most recent faulting transaction.
- `mmio_read`  out  1  registered device read request.
- `mmio_write`  out  1  registered device write request.
- `mmio_addr`  out  32  registered; stable for the whole transaction.
- `mmio_write_data`  out  32  registered.
- `mmio_work`  in  NDEV  per-device address claim; combinational from `mmio_addr`.
- `mmio_done`  in  NDEV  per-device completion pulse.
- `mmio_read_data`  in  NDEV*32  device i drives bits [32i+31:32i]; valid only while its done is high.

## Operation
States: IDLE, REQ, RESP, ERR.
- IDLE
  - Exactly one of read/write requested: latch addr/wdata/direction into the `mmio_*` registers, clear the timeout counter, go to REQ.
  - Both read and write requested: latch `fault_addr` = `cpu_addr`, go to ERR with no bus activity.
- REQ
  - `mmio_read` or `mmio_write` is held high.
  - Each cycle, check `mmio_work`.
    - If it is not exactly one-hot: go to ERR, latch `fault_addr`.
    - Otherwise the selected index is s. Done bits of other devices are ignored.
  - `mmio_done[s]` = 1: capture `mmio_read_data[s]` (reads only), deassert request, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 without done: go to ERR, latch `fault_addr`.
- RESP: `cpu_ack` = 1, `cpu_fault` = 0, `cpu_rdata` = captured data; go to IDLE.
- ERR: request lines already 0; `cpu_ack` = 1, `cpu_fault` = 1, `cpu_rdata` = 0; go to IDLE.
- Request lines are deasserted in the cycle after done is seen. Responders re-trigger if the request is held after done.
- The CPU still holds its request during the ack cycle. It is not re-accepted because the FSM is not in IDLE. The next request can be accepted in the following IDLE cycle.
- Writes to read-only devices complete normally (no fault) if the device returns done.
- Counter width: clog2(TIMEOUT)+1 bits; no wrap-around possible.

## Timing
- Reset values:
  - State IDLE.
  - `cpu_ack`, `cpu_fault`, `mmio_read`, `mmio_write` = 0.
  - `cpu_rdata`, `mmio_addr`, `mmio_write_data`, `fault_addr`, counter = 0.
- Reset mid-transaction: request lines drop in the next cycle and no ack is generated. The CPU must reissue.
- Cycle numbering: the request is first seen in IDLE at cycle 0, and REQ starts at cycle 1.
- A responder that raises done at cycle 1+k acks at cycle 2+k. For a single-cycle device (k=1), the ack is at cycle 3.
- Decode error: ack + fault at cycle 2.
- Timeout: ack + fault at cycle TIMEOUT+1.
- Illegal read+write: ack + fault at cycle 1.
- Back-to-back transactions: minimum 4 cycles per transaction for a single-cycle device.

## Test plan
- Read 0xFFFFE004 from a ROM at device 0 that returns 0xDEADBEEF -> `mmio_read` high in cycles 1-2, low in cycle 3; `cpu_ack` at cycle 3 with rdata 0xDEADBEEF, fault 0.
- Write 0x12345678 to 0xFFFFE000 -> `mmio_write_data` = 0x12345678 held through done; ack at cycle 3, fault 0, rdata 0.
- Unmapped address 0x00001000 (`mmio_work` = 0) -> ack + fault at cycle 2, `fault_addr` = 0x00001000; no done awaited.
- With TIMEOUT=8, a device claims but never signals done -> request held in cycles 1-8; ack + fault at cycle 9, request low in cycle 9.
- `cpu_req_read` and `cpu_req_write` both high -> no `mmio_read`/`mmio_write` ever asserted; ack + fault at cycle 1.
- `rst_n` low during REQ cycle 1 -> `mmio_read` = 0 and state IDLE next cycle; no `cpu_ack`. A read reissued after reset completes normally; two back-to-back reads ack at cycles 3 and 7.
